// File: rtl/ofdm_cp_inserter_if.sv
// ofdm_cp_inserter_if
//   Streaming bundle between the IFFT, the CP inserter and the DAC side.
//   Input stream : in_data / in_valid  (producer -> inserter), in_ready back.
//   Output stream: out_data / out_valid (inserter -> consumer), out_ready back.
//   Modports:
//     slave  - the CP inserter's view (consumes input stream, produces output).
//     master - the surrounding environment's view (feeds input, drains output).
interface ofdm_cp_inserter_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ofdm_cp_inserter.sv
// ofdm_cp_inserter
//   Transmit-side OFDM symbol framer. Buffers one N-sample symbol, then
//   emits the last NCP samples (cyclic prefix) followed by all N samples.
//   Repeats for num_sym symbols per accepted go.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   go         frame start, sampled only in IDLE
//   num_sym    symbols in the frame, latched on accepted go (0 ignores go)
//   strm       slave side of the sample streams (in_* / out_*)
//   sym_start  high with the first CP sample of each symbol
//   busy       high in every state except IDLE
//   done       one-cycle pulse when the frame completes
module ofdm_cp_inserter #(
  parameter int N   = 64,
  parameter int NCP = 16,
  parameter int DW  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [7:0]           num_sym,
  ofdm_cp_inserter_if.slave    strm,
  output logic                 sym_start,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] CP_START = AW'(N - NCP);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CP   = 3'd2;
  localparam logic [2:0] S_BODY = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    sym_cnt_q, sym_cnt_d;
  logic [7:0]    num_sym_q, num_sym_d;
  logic [7:0]    sym_cnt_inc;

  // Symbol store; contents survive reset and are overwritten on each load.
  logic [DW-1:0] buf_q [N];

  logic in_xfer;
  logic out_xfer;
  logic emitting;

  assign emitting    = (state_q == S_CP) || (state_q == S_BODY);
  assign in_xfer     = (state_q == S_LOAD) && strm.in_valid;
  assign out_xfer    = emitting && strm.out_ready;
  // num_sym_q <= 255 and sym_cnt_q < num_sym_q while emitting, so this never wraps.
  assign sym_cnt_inc = sym_cnt_q + 8'd1;

  // Outputs are pure decodes of registered state, so they sit still under
  // backpressure and read as zero whenever the stream is idle.
  assign strm.in_ready  = (state_q == S_LOAD);
  assign strm.out_valid = emitting;
  assign strm.out_data  = emitting ? buf_q[rd_idx_q] : '0;
  assign sym_start      = (state_q == S_CP) && (rd_idx_q == CP_START);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    sym_cnt_d = sym_cnt_q;
    num_sym_d = num_sym_q;

    case (state_q)
      S_IDLE: begin
        if (go && (num_sym != 8'd0)) begin
          num_sym_d = num_sym;
          sym_cnt_d = 8'd0;
          wr_idx_d  = '0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_xfer) begin
          // N is a power of two, so the increment wraps to 0 on its own.
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            rd_idx_d = CP_START;
            state_d  = S_CP;
          end
        end
      end

      S_CP: begin
        if (out_xfer) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            state_d = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (out_xfer) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            sym_cnt_d = sym_cnt_inc;
            if (sym_cnt_inc < num_sym_q) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      sym_cnt_q <= 8'd0;
      num_sym_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      sym_cnt_q <= sym_cnt_d;
      num_sym_q <= num_sym_d;
    end
  end

  // Writes are gated by LOAD, so stray in_valid elsewhere never touches the store.
  always_ff @(posedge clk) begin
    if (in_xfer && !reset) begin
      buf_q[wr_idx_q] <= strm.in_data;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// tb_ofdm_cp_inserter
//   Directed bench for ofdm_cp_inserter (N=64, NCP=16, DW=32). Expected output
//   samples are queued when a symbol is scheduled and popped on each output
//   transfer. One line per failed comparison; one summary line at the end.
module tb_ofdm_cp_inserter;

  localparam int N   = 64;
  localparam int NCP = 16;
  localparam int DW  = 32;
  localparam int SYM_CYC = 2 * N + NCP;

  typedef struct {
    logic [DW-1:0] d;
    logic          sos;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] num_sym;
  logic       sym_start;
  logic       busy;
  logic       done;

  ofdm_cp_inserter_if #(.DW(DW)) bus ();

  ofdm_cp_inserter #(.N(N), .NCP(NCP), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .num_sym   (num_sym),
    .strm      (bus),
    .sym_start (sym_start),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] src_q[$];

  logic          in_xfer;
  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic          hold_ss;
  int            done_cnt, done_cyc, inr_cnt, out_cnt, ss_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    in_xfer = 1'b0;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      in_xfer = bus.in_valid && bus.in_ready;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.in_ready) inr_cnt++;
      if (!bus.out_valid) begin
        chk("idle_out_data", bus.out_data, 32'd0);
        chk("idle_sym_start", {31'd0, sym_start}, 32'd0);
      end
      if (hold_v) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", bus.out_data, hold_d);
        chk("hold_sym_start", {31'd0, sym_start}, {31'd0, hold_ss});
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sym_start) ss_cnt++;
        chk("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("sym_start", {31'd0, sym_start}, {31'd0, e.sos});
        end
      end
      hold_v  = bus.out_valid && !bus.out_ready;
      hold_d  = bus.out_data;
      hold_ss = sym_start;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic schedule(input int k_sym);
    exp_t e;
    for (int s = 0; s < k_sym; s++) begin
      for (int i = 0; i < N; i++) src_q.push_back(DW'(s * 100 + i));
      for (int i = N - NCP; i < N; i++) begin
        e.d = DW'(s * 100 + i);
        e.sos = (i == N - NCP);
        exp_q.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
        e.d = DW'(s * 100 + i);
        e.sos = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Runs one frame. stop_after>0 stops after that many output transfers
  // (frame left mid-flight); otherwise runs until done and checks the frame.
  task automatic run_frame(input int k_sym, input bit rnd_in, input bit rnd_out,
                           input bit garbage, input bit go_mid, input int stop_after,
                           input bit chk_time);
    int  go_cyc;
    bit  mid_fired;
    mid_fired = 1'b0;
    done_cnt = 0; inr_cnt = 0; out_cnt = 0; ss_cnt = 0; done_cyc = -1;
    schedule(k_sym);
    go = 1'b1;
    num_sym = 8'(k_sym);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    go_cyc = cyc;
    cycle();
    go = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      go = 1'b0;
      if (go_mid && !mid_fired && out_cnt == 40) begin
        go = 1'b1;
        num_sym = 8'd9;
        mid_fired = 1'b1;
      end
      if (src_q.size() > 0) begin
        bus.in_valid = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_data  = src_q[0];
      end else if (garbage) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end
      bus.out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      if (in_xfer && src_q.size() > 0) void'(src_q.pop_front());
      if (stop_after > 0 ? (out_cnt >= stop_after) : (done_cnt > 0)) break;
    end
    go = 1'b0;
    if (stop_after == 0) begin
      chk("done_count", done_cnt, 32'd1);
      chk("exp_left", exp_q.size(), 32'd0);
      chk("src_left", src_q.size(), 32'd0);
      chk("sym_start_count", ss_cnt, 32'(k_sym));
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_width", {31'd0, done}, 32'd0);
      if (chk_time) begin
        chk("done_latency", done_cyc - go_cyc, 32'(1 + k_sym * SYM_CYC));
        chk("in_ready_cycles", inr_cnt, 32'(k_sym * N));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_sym_start"}, {31'd0, sym_start}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0;
    num_sym = 8'd0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    hold_v = 1'b0;
    hold_d = '0;
    hold_ss = 1'b0;
    in_xfer = 1'b0;
    cycle();
    cycle();
    check_idle("reset");
    reset = 1'b0;
    cycle();

    // Single symbol, full throughput.
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    // Three symbols back to back.
    run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    // Random gaps on both streams.
    run_frame(1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // go with num_sym = 0 must be ignored, even with input offered.
    done_cnt = 0; inr_cnt = 0;
    go = 1'b1;
    num_sym = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    cycle();
    go = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    bus.in_valid = 1'b0;
    check_idle("zero_sym");
    chk("zero_sym_done", done_cnt, 32'd0);
    chk("zero_sym_in_ready", inr_cnt, 32'd0);

    // go pulsed during BODY, garbage on the input outside LOAD.
    run_frame(1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    cycle();
    check_idle("post_go_mid");

    // Reset after five CP samples, then a clean frame.
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    check_idle("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    cycle();
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_inserter.md
# ofdm_cp_inserter

Transmit-side OFDM symbol framer. It buffers one N-sample time-domain symbol from the IFFT, then emits the symbol with its cyclic prefix prepended: the last NCP samples followed by all N samples. This builds the CP-structured stream that the receive-side sample-timing-offset estimator correlates against. The block sits between the IFFT output and the DAC/channel model and frames a burst of `num_sym` symbols per `go`.

## Interface
- `N`, 64: samples per OFDM symbol (power of 2, 8..1024)
- `NCP`, 16: cyclic-prefix length (1..N-1)
- `DW`, 32: sample width ({I,Q} packed, I in upper half)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `go`  in  1  start a frame; sampled only in IDLE
- `num_sym`  in  8  symbols in frame; latched on accepted `go`
- `in_data`  in  DW  input sample
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block accepts input (LOAD state only)
- `out_data`  out  DW  output sample; 0 when `out_valid`=0
- `out_valid`  out  1  output sample valid
- `out_ready`  in  1  downstream accepts output
- `sym_start`  out  1  high with first CP sample of each symbol
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame end

## Operation
- Storage: N x DW register array, write index `wr_idx`, read index `rd_idx` (log2 N bits), symbol counter `sym_cnt` (8 bits).
- An input transfer occurs on `in_valid & in_ready`. An output transfer occurs on `out_valid & out_ready`.
- States:
  - IDLE: all outputs 0. If `go`=1 and `num_sym`≠0, latch `num_sym`, clear `sym_cnt`, go to LOAD. A `go` with `num_sym`=0 is ignored and the block stays in IDLE.
  - LOAD: `in_ready`=1. Each input transfer writes `buf[wr_idx]` and increments `wr_idx`. The transfer at `wr_idx`=N-1 wraps `wr_idx` to 0, sets `rd_idx`=N-NCP, and moves to CP.
  - CP: `out_valid`=1, `out_data`=`buf[rd_idx]` (combinational read). Each output transfer increments `rd_idx`. The transfer at `rd_idx`=N-1 wraps `rd_idx` to 0 and moves to BODY.
  - BODY: `out_valid`=1, `out_data`=`buf[rd_idx]`. The transfer at `rd_idx`=N-1 increments `sym_cnt`. If `sym_cnt`+1 < latched `num_sym`, go to LOAD; otherwise go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `sym_start` = (state==CP) & (`rd_idx`==N-NCP) & `out_valid`. It stays high while the first CP sample is held under backpressure.
- `go` outside IDLE is ignored. `in_valid` outside LOAD is ignored and the data is not stored.
- `out_data` and `out_valid` hold stable while `out_ready`=0 (AXI-style; no valid drop without a transfer).
- Reset, including reset mid-frame: next state is IDLE, `wr_idx`/`rd_idx`/`sym_cnt` are 0, and all outputs are 0. Buffer contents are not cleared (don't-care). A partially emitted symbol is abandoned.
- `sym_cnt` cannot overflow: `num_sym`≤255 and the counter compares before incrementing.

## Timing
- `go` accepted in cycle t: `in_ready`=1 and `busy`=1 from t+1.
- Last input transfer in cycle L: `in_ready`=0 and `out_valid`=1 with `buf[N-NCP]` from L+1. The block adds no extra pipeline cycle.
- With `in_valid` and `out_ready` held high, each symbol takes exactly N load cycles plus N+NCP output cycles. Load and output never overlap (single buffer).
- Last BODY transfer in cycle E: if the frame is complete, `done`=1 in E+1 and `busy`=0 from E+2. If not, `in_ready`=1 in E+1.
- Frame of K symbols, full throughput, `go` at t: `done` at t+1+K·(2N+NCP).

## Test plan
- N=64, NCP=16, `num_sym`=1, input ramp 0..63, `out_ready`=1 -> output sequence 48..63 then 0..63 (80 samples). `sym_start` high only with sample 48. `done` pulse 145 cycles after `go` (t+1+144).
- `num_sym`=3, ramps offset by 100·k -> three 80-sample framed symbols, three `sym_start` pulses, one `done` at t+433. `in_ready` high during exactly three 64-cycle windows.
- Random `out_ready` (50%) and `in_valid` (50%) gaps -> identical output sequence to the first scenario. `out_data` stable whenever `out_valid`=1 and `out_ready`=0. No sample dropped or duplicated.
- `go`=1 with `num_sym`=0 -> stays IDLE, `busy`=0, `in_ready`=0, no `done`. `go` pulsed during BODY -> no effect on the sequence or count.
- `reset` asserted mid-CP (after 5 output samples) -> next cycle all outputs 0 and IDLE. A fresh `go` then reproduces the first scenario exactly.
- `in_valid`=1 while in CP/BODY with garbage data -> ignored; output matches the buffered symbol.
